// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and writeback arbitration pointer encoding
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LD  = 1'b1
  } pri_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a registered priority pointer
module rr_arb2
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_ld,
  output logic gnt_alu,
  output logic gnt_ld
);

  pri_e ptr;
  pri_e ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PRI_ALU;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Grants are pure functions of requests and pointer, so ready never loops back into valid.
  always_comb begin
    gnt_alu  = 1'b0;
    gnt_ld   = 1'b0;
    ptr_next = ptr;
    if (rst_n) begin
      gnt_alu = req_alu && (!req_ld || (ptr == PRI_ALU));
      gnt_ld  = req_ld && (!req_alu || (ptr == PRI_LD));
    end
    if (gnt_alu) begin
      ptr_next = PRI_LD;
    end else if (gnt_ld) begin
      ptr_next = PRI_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// rtl/regfile_wb_arb.sv - ALU/load writeback arbiter with busy scoreboard
// Optional macro REGFILE_WB_FWD_EN suppresses hazards on the register being written this cycle.
module regfile_wb_arb
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_W-1:0]       alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_W-1:0]       ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   iss_valid,
  input  logic [REG_W-1:0]       iss_rd,
  input  logic [REG_W-1:0]       rs1,
  input  logic [REG_W-1:0]       rs2,
  output logic                   haz_rs1,
  output logic                   haz_rs2,
  output logic                   we,
  output logic [REG_W-1:0]       rd,
  output logic [XLEN-1:0]        rd_data
);

  logic             gnt_alu;
  logic             gnt_ld;
  logic             gnt_any;
  logic [REG_W-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic             fwd_rs1;
  logic             fwd_rs2;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (alu_valid),
    .req_ld  (ld_valid),
    .gnt_alu (gnt_alu),
    .gnt_ld  (gnt_ld)
  );

  assign alu_ready = gnt_alu;
  assign ld_ready  = gnt_ld;
  assign gnt_any   = gnt_alu || gnt_ld;

  always_comb begin
    sel_rd   = ld_rd;
    sel_data = ld_data;
    if (gnt_alu) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // x0 writes still handshake but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      rd      <= '0;
      rd_data <= '0;
    end else begin
      we <= gnt_any && (sel_rd != '0);
      if (gnt_any) begin
        rd      <= sel_rd;
        rd_data <= sel_data;
      end
    end
  end

  // Clear first, then set, so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (we) begin
      busy_next[rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_next[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_rs1 = we && (rd == rs1);
  assign fwd_rs2 = we && (rd == rs2);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  assign haz_rs1 = (rs1 != '0) && busy[rs1] && !fwd_rs1;
  assign haz_rs2 = (rs2 != '0) && busy[rs2] && !fwd_rs2;

endmodule
